// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU issue controller:
//   - 4-bit ALU control codes driven onto alu_cntl
//   - MIPS R-type funct values the controller understands
//   - issue FSM state encoding
//   - decoded-funct bundle produced by alu_funct_decode
package alu_pkg;

  // ALU control codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADDU = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUBU = 4'b0110;
  localparam logic [3:0] ALU_NOT  = 4'b0111;
  localparam logic [3:0] ALU_ADDS = 4'b1010;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SLL  = 4'b1101;
  localparam logic [3:0] ALU_SUBS = 4'b1110;

  // MIPS funct field values
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_NOT  = 6'h3F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] cntl;
    logic       supported;
    logic       is_logical;
    logic       is_signed;
  } decode_t;

endpackage

// File: rtl/alu_funct_decode.sv
// alu_funct_decode
// Purely combinational translation of a MIPS funct field into the ALU
// control code plus the attributes the issue controller needs when it
// sanitises flags.
// Ports:
//   funct : input  [5:0]   MIPS funct field
//   dec   : output decode_t {cntl, supported, is_logical, is_signed}
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [5:0] funct,
  output decode_t    dec
);

  // Unsupported functs fall through with everything zero, so cntl stays AND
  always_comb begin
    dec = '0;
    case (funct)
      FN_ADD:  begin dec.cntl = ALU_ADDS; dec.supported = 1'b1; dec.is_signed  = 1'b1; end
      FN_ADDU: begin dec.cntl = ALU_ADDU; dec.supported = 1'b1; end
      FN_SUB:  begin dec.cntl = ALU_SUBS; dec.supported = 1'b1; dec.is_signed  = 1'b1; end
      FN_SUBU: begin dec.cntl = ALU_SUBU; dec.supported = 1'b1; end
      FN_AND:  begin dec.cntl = ALU_AND;  dec.supported = 1'b1; dec.is_logical = 1'b1; end
      FN_OR:   begin dec.cntl = ALU_OR;   dec.supported = 1'b1; dec.is_logical = 1'b1; end
      FN_XOR:  begin dec.cntl = ALU_XOR;  dec.supported = 1'b1; dec.is_logical = 1'b1; end
      FN_NOR:  begin dec.cntl = ALU_NOR;  dec.supported = 1'b1; dec.is_logical = 1'b1; end
      FN_SLL:  begin dec.cntl = ALU_SLL;  dec.supported = 1'b1; end
      FN_NOT:  begin dec.cntl = ALU_NOT;  dec.supported = 1'b1; dec.is_logical = 1'b1; end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Front-end between decode and the datapath ALU. Accepts one R-type op over
// a valid/ready handshake, drives the ALU for a single cycle, captures the
// result with sanitised flags and holds it until the consumer takes it.
// Also keeps saturating counts of accepted ops and unsupported-funct errors.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   in_valid/in_ready             request handshake
//   in_funct, in_a, in_b          request payload
//   alu_a, alu_b, alu_cntl        drive to ALU (zero / AND when idle)
//   alu_out, alu_n/z/c/v          ALU result and flags
//   out_valid/out_ready           result handshake
//   out_result, out_n/z/c/v       captured result and flags
//   out_err, out_trap             unsupported funct / signed overflow
//   op_count, err_count           saturating statistics
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_funct,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_cntl,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_n,
  output logic              out_z,
  output logic              out_c,
  output logic              out_v,
  output logic              out_err,
  output logic              out_trap,
  output logic [CNT_W-1:0]  op_count,
  output logic [CNT_W-1:0]  err_count
);

  state_t            state, state_next;
  decode_t           dec;
  logic [3:0]        lat_cntl;
  logic              lat_logical;
  logic              lat_signed;
  logic [DATA_W-1:0] lat_a, lat_b;
  logic              accept;
  logic              driving;

  alu_funct_decode u_decode (
    .funct (in_funct),
    .dec   (dec)
  );

  assign accept    = (state == ST_IDLE) && in_valid;
  assign driving   = (state == ST_DRIVE);
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // The ALU only sees real operands during DRIVE; otherwise it idles on AND of zero
  assign alu_a    = driving ? lat_a    : '0;
  assign alu_b    = driving ? lat_b    : '0;
  assign alu_cntl = driving ? lat_cntl : ALU_AND;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Unsupported ops skip DRIVE entirely; DONE leaving on out_ready means a
  // request arriving that same cycle waits for the following IDLE cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (in_valid) state_next = dec.supported ? ST_DRIVE : ST_DONE;
      ST_DRIVE: state_next = ST_DONE;
      ST_DONE:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Request latch and result capture. Logical ops have no meaningful carry or
  // overflow, and sll has no overflow, so those flags are forced low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_cntl    <= ALU_AND;
      lat_logical <= 1'b0;
      lat_signed  <= 1'b0;
      lat_a       <= '0;
      lat_b       <= '0;
      out_result  <= '0;
      out_n       <= 1'b0;
      out_z       <= 1'b0;
      out_c       <= 1'b0;
      out_v       <= 1'b0;
      out_err     <= 1'b0;
      out_trap    <= 1'b0;
    end else if (accept) begin
      lat_cntl    <= dec.cntl;
      lat_logical <= dec.is_logical;
      lat_signed  <= dec.is_signed;
      lat_a       <= in_a;
      lat_b       <= in_b;
      if (!dec.supported) begin
        out_result <= '0;
        out_n      <= 1'b0;
        out_z      <= 1'b0;
        out_c      <= 1'b0;
        out_v      <= 1'b0;
        out_err    <= 1'b1;
        out_trap   <= 1'b0;
      end
    end else if (driving) begin
      out_result <= alu_out;
      out_n      <= alu_n;
      out_z      <= alu_z;
      out_c      <= lat_logical ? 1'b0 : alu_c;
      out_v      <= (lat_logical || (lat_cntl == ALU_SLL)) ? 1'b0 : alu_v;
      out_err    <= 1'b0;
      out_trap   <= lat_signed & alu_v;
    end
  end

  // Statistics counters stick at all-ones rather than wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_count  <= '0;
      err_count <= '0;
    end else if (accept) begin
      if (op_count != '1) op_count <= op_count + CNT_W'(1);
      if (!dec.supported && (err_count != '1)) err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
// Directed bench for alu_issue_ctrl with a behavioural ALU attached to the
// alu_* ports. Counters are built 2 bits wide so saturation is reachable.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [5:0]  in_funct;
  logic [31:0] in_a, in_b;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_cntl;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_n, out_z, out_c, out_v, out_err, out_trap;
  logic [1:0]  op_count, err_count;
  logic        force_cv;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(32), .CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cntl(alu_cntl),
    .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_n(out_n), .out_z(out_z), .out_c(out_c), .out_v(out_v),
    .out_err(out_err), .out_trap(out_trap),
    .op_count(op_count), .err_count(err_count)
  );

  // Behavioural ALU; force_cv lets the bench inject carry/overflow on ops
  // whose flags the controller is expected to mask.
  logic [32:0] wide;
  always_comb begin
    wide    = '0;
    alu_out = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_cntl)
      4'b0000: begin alu_out = alu_a & alu_b;    alu_c = force_cv; alu_v = force_cv; end
      4'b0001: begin alu_out = alu_a | alu_b;    alu_c = force_cv; alu_v = force_cv; end
      4'b0011: begin alu_out = alu_a ^ alu_b;    alu_c = force_cv; alu_v = force_cv; end
      4'b1100: begin alu_out = ~(alu_a | alu_b); alu_c = force_cv; alu_v = force_cv; end
      4'b0111: begin alu_out = ~alu_a;           alu_c = force_cv; alu_v = force_cv; end
      4'b0010, 4'b1010: begin
        wide    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = wide[31:0];
        alu_c   = wide[32];
        alu_v   = (alu_a[31] == alu_b[31]) && (wide[31] != alu_a[31]);
      end
      4'b0110, 4'b1110: begin
        wide    = {1'b0, alu_a} - {1'b0, alu_b};
        alu_out = wide[31:0];
        alu_c   = ~wide[32];
        alu_v   = (alu_a[31] != alu_b[31]) && (wide[31] != alu_a[31]);
      end
      4'b1101: begin alu_out = alu_a << 1; alu_c = alu_a[31]; alu_v = force_cv; end
      default: alu_out = '0;
    endcase
    alu_n = alu_out[31];
    alu_z = (alu_out == 32'd0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single accept edge, then drops in_valid
  task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_funct = f;
    in_a     = a;
    in_b     = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_funct  = 6'h00;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    force_cv  = 1'b0;
    #12;
    checkOutput("reset_in_ready",  in_ready,   1);
    checkOutput("reset_out_valid", out_valid,  0);
    checkOutput("reset_alu_cntl",  alu_cntl,   0);
    checkOutput("reset_result",    out_result, 0);
    checkOutput("reset_op_count",  op_count,   0);
    step();
    reset_n = 1'b1;
    step();

    // addu 0xFFFFFFFF + 1
    applyStimulus(6'h21, 32'hFFFF_FFFF, 32'h1);
    checkOutput("addu_drive_cntl",  alu_cntl,  4'b0010);
    checkOutput("addu_drive_valid", out_valid, 0);
    checkOutput("addu_drive_ready", in_ready,  0);
    step();
    checkOutput("addu_valid",  out_valid,  1);
    checkOutput("addu_result", out_result, 0);
    checkOutput("addu_z",      out_z,      1);
    checkOutput("addu_c",      out_c,      1);
    checkOutput("addu_n",      out_n,      0);
    checkOutput("addu_trap",   out_trap,   0);
    consume();
    checkOutput("addu_back_idle", in_ready, 1);
    checkOutput("addu_op_count",  op_count, 1);

    // signed add overflow, then 5 cycles of backpressure with a pending request
    applyStimulus(6'h20, 32'h7FFF_FFFF, 32'h1);
    step();
    checkOutput("add_result", out_result, 32'h8000_0000);
    checkOutput("add_n",      out_n,      1);
    checkOutput("add_v",      out_v,      1);
    checkOutput("add_trap",   out_trap,   1);
    force_cv  = 1'b1;
    in_valid  = 1'b1;
    in_funct  = 6'h27;
    in_a      = 32'h0;
    in_b      = 32'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("bp_valid",    out_valid,  1);
      checkOutput("bp_in_ready", in_ready,   0);
      checkOutput("bp_result",   out_result, 32'h8000_0000);
      checkOutput("bp_trap",     out_trap,   1);
    end
    checkOutput("bp_op_count", op_count, 2);

    // out_ready in DONE with in_valid high: request waits one IDLE cycle
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("done_rdy_idle",  in_ready,  1);
    checkOutput("done_rdy_valid", out_valid, 0);
    checkOutput("done_rdy_count", op_count,  2);
    step();
    in_valid = 1'b0;
    checkOutput("nor_drive_cntl", alu_cntl, 4'b1100);
    step();
    checkOutput("nor_result", out_result, 32'hFFFF_FFFF);
    checkOutput("nor_c",      out_c,      0);
    checkOutput("nor_v",      out_v,      0);
    checkOutput("nor_n",      out_n,      1);
    checkOutput("nor_z",      out_z,      0);
    checkOutput("nor_count",  op_count,   3);
    consume();

    // unsupported funct: done one cycle after accept, ALU never driven
    applyStimulus(6'h2A, 32'h5, 32'h3);
    checkOutput("bad_valid",  out_valid,  1);
    checkOutput("bad_err",    out_err,    1);
    checkOutput("bad_result", out_result, 0);
    checkOutput("bad_flags",  {out_n, out_z, out_c, out_v, out_trap}, 0);
    checkOutput("bad_cntl",   alu_cntl,   0);
    checkOutput("bad_errcnt", err_count,  1);
    checkOutput("sat_count4", op_count,   3);
    consume();
    checkOutput("bad_cntl_idle", alu_cntl, 0);

    // fifth op: counter stays saturated; and masks injected carry/overflow
    applyStimulus(6'h24, 32'hF0, 32'h3C);
    step();
    checkOutput("and_result", out_result, 32'h30);
    checkOutput("and_cv",     {out_c, out_v}, 0);
    checkOutput("and_err",    out_err,    0);
    checkOutput("sat_count5", op_count,   3);
    consume();

    // sll: carry kept, overflow masked
    applyStimulus(6'h00, 32'h8000_0001, 32'h0);
    checkOutput("sll_cntl", alu_cntl, 4'b1101);
    step();
    checkOutput("sll_result", out_result, 32'h2);
    checkOutput("sll_c",      out_c,      1);
    checkOutput("sll_v",      out_v,      0);
    consume();
    force_cv = 1'b0;

    // signed sub overflow
    applyStimulus(6'h22, 32'h8000_0000, 32'h1);
    step();
    checkOutput("sub_result", out_result, 32'h7FFF_FFFF);
    checkOutput("sub_c",      out_c,      1);
    checkOutput("sub_trap",   out_trap,   1);
    consume();

    // asynchronous reset while in DRIVE
    applyStimulus(6'h21, 32'h1, 32'h2);
    checkOutput("rst_pre_cntl", alu_cntl, 4'b0010);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_valid",    out_valid,  0);
    checkOutput("rst_ready",    in_ready,   1);
    checkOutput("rst_op_count", op_count,   0);
    checkOutput("rst_err_count", err_count, 0);
    checkOutput("rst_alu_cntl", alu_cntl,   0);
    checkOutput("rst_alu_a",    alu_a,      0);
    checkOutput("rst_result",   out_result, 0);
    reset_n = 1'b1;
    step();
    checkOutput("rst_after_valid", out_valid, 0);
    checkOutput("rst_after_ready", in_ready,  1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
